// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, opcodes and FSM encoding for the ALU issue stage
package alu_pkg;

    localparam int NREGS     = 4;
    localparam int REG_IDX_W = 2;
    localparam int DATA_W    = 8;
    localparam int OP_W      = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;
    localparam logic [OP_W-1:0] OP_LSL = 3'b110;
    localparam logic [OP_W-1:0] OP_LSR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction handshake and result strobe bundle for alu_issue
//   instr_valid/instr_ready : instruction handshake
//   instr_op/rd/ra/rb       : opcode and register indices
//   res_valid/data/zero     : one-cycle result strobe and held result
interface alu_issue_if;
    import alu_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [OP_W-1:0]      instr_op;
    logic [REG_IDX_W-1:0] instr_rd;
    logic [REG_IDX_W-1:0] instr_ra;
    logic [REG_IDX_W-1:0] instr_rb;
    logic                 res_valid;
    logic [DATA_W-1:0]    res_data;
    logic                 res_zero;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        input  instr_ready, res_valid, res_data, res_zero
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        output instr_ready, res_valid, res_data, res_zero
    );

endinterface

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - 4x8 register file, two async read ports, writeback and load write ports
//   clk, rst         : clock, async active-high reset (clears all entries)
//   ra_idx/ra_data   : read port A
//   rb_idx/rb_data   : read port B
//   wb_en/idx/data   : writeback port (wins over load on the same index)
//   ld_en/idx/data   : direct load port
module regfile4x8
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] ra_idx,
    output logic [DATA_W-1:0]    ra_data,
    input  logic [REG_IDX_W-1:0] rb_idx,
    output logic [DATA_W-1:0]    rb_data,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_idx,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_idx,
    input  logic [DATA_W-1:0]    ld_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                // A load colliding with writeback on the same entry is dropped.
                if (wb_en && (wb_idx == REG_IDX_W'(i))) begin
                    regs[i] <= wb_data;
                end else if (ld_en && (ld_idx == REG_IDX_W'(i))) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    assign ra_data = regs[ra_idx];
    assign rb_data = regs[rb_idx];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback stage feeding an external 8-bit ALU
//   clk, rst                 : clock, async active-high reset
//   bus (slave)              : instruction handshake in, result strobe out
//   ld_en/ld_reg/ld_data     : direct register load, honoured in every state
//   alu_opcode/alu_a/alu_b   : registered ALU inputs, held outside EXEC
//   alu_d                    : combinational ALU result, captured in EXEC
//   busy                     : instruction in flight
module alu_issue
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_if.slave           bus,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_reg,
    input  logic [DATA_W-1:0]    ld_data,
    output logic [OP_W-1:0]      alu_opcode,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    input  logic [DATA_W-1:0]    alu_d,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] rd_q;
    logic [DATA_W-1:0]    rf_a;
    logic [DATA_W-1:0]    rf_b;
    logic [DATA_W-1:0]    res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        busy            = 1'b1;
        accept          = 1'b0;
        wb_en           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // A pending load blocks acceptance so operands are never
                // read on the same edge a register is being loaded.
                bus.instr_ready = !ld_en && !rst;
                accept          = bus.instr_valid && bus.instr_ready;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                wb_en     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            res_q      <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= bus.instr_op;
                alu_a      <= rf_a;
                alu_b      <= rf_b;
                rd_q       <= bus.instr_rd;
            end
            if (wb_en) begin
                res_q <= alu_d;
            end
        end
    end

    assign bus.res_data = res_q;
    assign bus.res_zero = (res_q == '0);

    regfile4x8 u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_idx  (bus.instr_ra),
        .ra_data (rf_a),
        .rb_idx  (bus.instr_rb),
        .rb_data (rf_b),
        .wb_en   (wb_en),
        .wb_idx  (rd_q),
        .wb_data (alu_d),
        .ld_en   (ld_en),
        .ld_idx  (ld_reg),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with a peer ALU and reference register model
module tb_alu_issue;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [1:0] ld_reg;
    logic [7:0] ld_data;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_d;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_rf [4];

    alu_issue_if bus();

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign alu_d = alu_f(alu_opcode, alu_a, alu_b);

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ld_en      (ld_en),
        .ld_reg     (ld_reg),
        .ld_data    (ld_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_d      (alu_d),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_reg = r; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        model_rf[r] = d;
    endtask

    // ld_mode: 0 none, 1 load in the IDLE cycle the instruction is offered, 2 load during EXEC
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input int ld_mode, input logic [1:0] lr,
                         input logic [7:0] ld);
        logic [7:0] ea, eb, er;
        int w;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = op; bus.instr_rd = rd; bus.instr_ra = ra; bus.instr_rb = rb;
        if (ld_mode == 1) begin
            ld_en = 1'b1; ld_reg = lr; ld_data = ld;
            #1 check("ready_blocked_by_load", 32'(bus.instr_ready), 32'd0);
            @(negedge clk);
            ld_en = 1'b0;
            model_rf[lr] = ld;
        end
        w = 0;
        #1;
        while (!bus.instr_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("accept_timeout", 32'(w < 20), 32'd1);
        ea = model_rf[ra];
        eb = model_rf[rb];
        er = alu_f(op, ea, eb);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (ld_mode == 2) begin
            ld_en = 1'b1; ld_reg = lr; ld_data = ld;
        end
        #1;
        check("exec_opcode", 32'(alu_opcode), 32'(op));
        check("exec_alu_a", 32'(alu_a), 32'(ea));
        check("exec_alu_b", 32'(alu_b), 32'(eb));
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ready", 32'(bus.instr_ready), 32'd0);
        check("exec_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        model_rf[rd] = er;
        if (ld_mode == 2 && lr != rd) model_rf[lr] = ld;
        #1;
        check("done_res_valid", 32'(bus.res_valid), 32'd1);
        check("done_res_data", 32'(bus.res_data), 32'(er));
        check("done_res_zero", 32'(bus.res_zero), 32'(er == 8'h00));
        check("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(bus.instr_ready), 32'd1);
        check("idle_res_hold", 32'(bus.res_data), 32'(er));
    endtask

    // OR r,r,r leaves the register unchanged and returns its value.
    task automatic read_reg(input logic [1:0] r);
        issue(OP_OR, r, r, r, 0, 2'd0, 8'h00);
    endtask

    initial begin
        logic [7:0] pend;
        rst = 1'b1;
        ld_en = 1'b0; ld_reg = '0; ld_data = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op = '0; bus.instr_rd = '0; bus.instr_ra = '0; bus.instr_rb = '0;
        pend = '0;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_zero", 32'(bus.res_zero), 32'd1);
        check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(bus.instr_ready), 32'd1);

        // Directed program
        load(2'd1, 8'h0F);
        load(2'd2, 8'h05);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00);
        read_reg(2'd3);
        issue(OP_SUB, 2'd0, 2'd2, 2'd2, 0, 2'd0, 8'h00);
        issue(OP_NOT, 2'd1, 2'd1, 2'd0, 0, 2'd0, 8'h00);
        issue(OP_AND, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00);

        // Back-to-back accepts every third cycle
        load(2'd1, 8'h03);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = OP_ADD; bus.instr_rd = 2'd0; bus.instr_ra = 2'd0; bus.instr_rb = 2'd1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check("b2b_ready", 32'(bus.instr_ready), 32'(k % 3 == 0));
            check("b2b_busy", 32'(busy), 32'(k % 3 != 0));
            check("b2b_res_valid", 32'(bus.res_valid), 32'(k % 3 == 2));
            if (k % 3 == 0) pend = model_rf[0] + model_rf[1];
            if (k % 3 == 2) begin
                check("b2b_res_data", 32'(bus.res_data), 32'(pend));
                model_rf[0] = pend;
            end
            if (k == 8) bus.instr_valid = 1'b0;
            @(negedge clk);
        end
        read_reg(2'd0);

        // Load in the offering cycle delays acceptance and is seen by the operand read
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1, 2'd1, 8'h33);

        // Writeback/load collision
        load(2'd1, 8'h0F);
        load(2'd2, 8'h05);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 2, 2'd3, 8'hAA);
        read_reg(2'd3);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 2, 2'd2, 8'hAA);
        read_reg(2'd2);

        // Reset in EXEC abandons the instruction
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = OP_ADD; bus.instr_rd = 2'd3; bus.instr_ra = 2'd1; bus.instr_rb = 2'd2;
        #1 check("rst_test_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res_zero", 32'(bus.res_zero), 32'd1);
        check("midrst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        #1 check("midrst_no_strobe", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        #1 check("midrst_release_ready", 32'(bus.instr_ready), 32'd1);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00);
        for (int i = 0; i < 4; i++) read_reg(2'(i));

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                  2'($urandom_range(3)), int'($urandom_range(2)), 2'($urandom_range(3)),
                  8'($urandom_range(255)));
        end
        for (int i = 0; i < 4; i++) read_reg(2'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
